// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, default timing, and the parity
// rule that both the transmit framer and the receiver must agree on.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_DATA_BITS    = 8;

    // Narrower words are zero-extended by the caller; extra zeros do not change the XOR.
    function automatic logic parity_calc(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while clear is low and raises
// bit_tick for the single cycle the count sits at its last value.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx;
    logic             tick_r;

    // Next count: hold at zero while cleared, wrap at the end of each bit period.
    always_comb begin
        cnt_nx = cnt_r;
        if (clear || (cnt_r == CNT_LAST)) begin
            cnt_nx = CNT_ZERO;
        end else begin
            cnt_nx = cnt_r + CNT_ONE;
        end
    end

    // Count and tick registers; the tick is pre-decoded so it is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= CNT_ZERO;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nx;
            tick_r <= (!clear) && (cnt_nx == CNT_LAST);
        end
    end

    assign bit_tick = tick_r;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word on a valid/ready handshake and shifts it
// out LSB first as start, data, optional parity and stop bits on a registered line.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 parity_out
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       ODD_SEL   = (PARITY_ODD != 0);

    uart_state_e          state_r, state_nx;
    logic [DATA_BITS-1:0] shift_r, shift_nx;
    logic [2:0]           bit_idx_r, bit_idx_nx;
    logic                 stop_idx_r, stop_idx_nx;
    logic                 parity_r, parity_nx;
    logic                 tx_out_r, tx_out_nx;
    logic                 tx_ready_r;
    logic                 tx_busy_r;
    logic                 bit_tick_s;
    logic                 handshake_s;
    logic                 baud_clear_s;

    assign handshake_s  = tx_valid && tx_ready_r;
    assign baud_clear_s = (state_r == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear_s),
        .bit_tick (bit_tick_s)
    );

    // Next-state, datapath and next line value; the line is derived from the next
    // state so the registered output changes on the same edge as the state.
    always_comb begin
        state_nx    = state_r;
        shift_nx    = shift_r;
        bit_idx_nx  = bit_idx_r;
        stop_idx_nx = stop_idx_r;
        parity_nx   = parity_r;
        tx_out_nx   = 1'b1;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    shift_nx    = tx_data;
                    parity_nx   = parity_calc(8'(tx_data), ODD_SEL);
                    bit_idx_nx  = 3'd0;
                    stop_idx_nx = 1'b0;
                    state_nx    = START;
                end else begin
                    state_nx = IDLE;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    state_nx = DATA;
                end else begin
                    state_nx = START;
                end
            end
            DATA: begin
                if (bit_tick_s) begin
                    shift_nx = shift_r >> 1;
                    if (bit_idx_r == LAST_BIT) begin
                        bit_idx_nx = 3'd0;
                        state_nx   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_nx = bit_idx_r + 3'd1;
                        state_nx   = DATA;
                    end
                end else begin
                    state_nx = DATA;
                end
            end
            PARITY: begin
                if (bit_tick_s) begin
                    state_nx = STOP;
                end else begin
                    state_nx = PARITY;
                end
            end
            STOP: begin
                if (bit_tick_s) begin
                    if (stop_idx_r == LAST_STOP) begin
                        stop_idx_nx = 1'b0;
                        state_nx    = IDLE;
                    end else begin
                        stop_idx_nx = 1'b1;
                        state_nx    = STOP;
                    end
                end else begin
                    state_nx = STOP;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        case (state_nx)
            IDLE:    tx_out_nx = 1'b1;
            START:   tx_out_nx = 1'b0;
            DATA:    tx_out_nx = shift_nx[0];
            PARITY:  tx_out_nx = parity_nx;
            STOP:    tx_out_nx = 1'b1;
            default: tx_out_nx = 1'b1;
        endcase
    end

    // State and output registers; reset parks the line high and abandons any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            shift_r    <= {DATA_BITS{1'b0}};
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            parity_r   <= 1'b0;
            tx_out_r   <= 1'b1;
            tx_ready_r <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            state_r    <= state_nx;
            shift_r    <= shift_nx;
            bit_idx_r  <= bit_idx_nx;
            stop_idx_r <= stop_idx_nx;
            parity_r   <= parity_nx;
            tx_out_r   <= tx_out_nx;
            tx_ready_r <= (state_nx == IDLE);
            tx_busy_r  <= (state_nx != IDLE);
        end
    end

    assign tx_out     = tx_out_r;
    assign tx_ready   = tx_ready_r;
    assign tx_busy    = tx_busy_r;
    assign parity_out = parity_r;

endmodule
